spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI master that drives the 11-bit command frame our SPI slave with single-port RAM accepts.
- Frame: check bit, 2-bit command, 8-bit payload. For a read-data command it also receives the 8-bit data the slave returns on MISO.
- Sits between an on-chip requester (CPU/test sequencer) and the SPI pins; its sclk/ss_n/mosi outputs drive the slave's clk/SS_n/MOSI inputs.
- Mode 0: sclk idles low, mosi changes on sclk falling edge, miso is sampled on sclk rising edge.

Parameters:
- CLK_DIV, 1, system clk cycles per sclk half-period (must be >= 1).
- RD_TURNAROUND, 2, sclk periods of ignored MISO between the read-data frame and the first returned bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request strobe; accepted only when busy=0.
- cmd  in  2  00 write address, 01 write data, 10 read address, 11 read data.
- payload  in  8  address or data byte, sent MSB first.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transaction completes.
- rd_data  out  8  byte received by the last read-data (cmd=11) transaction; holds its value otherwise.
- sclk  out  1  SPI clock.
- ss_n  out  1  slave select, active low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; sclk=0, ss_n=1, mosi=0, busy=0, done=0, rd_data=0.
  - Divider and bit counters cleared.
  - A transaction in flight is abandoned; no done pulse is issued.
- start while busy=1 is ignored. On accept, cmd and payload are latched into an 11-bit shift register {cmd[1], cmd[1], cmd[0], payload[7:0]}; later input changes have no effect.
- Divider: count 0..CLK_DIV-1 while not IDLE, then toggle sclk (during SHIFT_TX/TURN/SHIFT_RX only).
  - Produces rise_en/fall_en pulses.
  - One sclk period (T) = 2*CLK_DIV clk cycles.
- FSM (all timing in T):
  - IDLE: ss_n=1, sclk=0. On start: go to SETUP, busy=1.
  - SETUP (1 T): ss_n=0, mosi=frame bit 10. sclk stays low.
  - SHIFT_TX (11 T):
    - Slave samples bit k on rising edge k; master shifts the next bit onto mosi on each falling edge.
    - A 4-bit counter counts 11 rising edges.
    - After the 11th falling edge: go to TURN if cmd=11, else HOLD.
  - TURN (RD_TURNAROUND T): sclk keeps toggling, mosi=0, miso ignored.
  - SHIFT_RX (8 T): on each rising edge, rd_shift <= {rd_shift[6:0], miso} (MSB first). After the 8th rising edge, rd_data <= rd_shift.
  - HOLD (1 T): sclk low, ss_n still 0.
  - GAP (1 T): ss_n=1. Last clk of GAP: done=1 for one cycle; next cycle IDLE, busy=0.
- Total busy time:
  - cmd 00/01/10: 14 T.
  - cmd 11: (22 + RD_TURNAROUND) T, i.e. 24 T at default.
- start asserted in the same cycle done=1 is ignored (busy still 1); it is accepted in the following IDLE cycle.
- ss_n never glitches inside a frame. mosi is stable across every sclk rising edge.
- rd_data is updated only by a completed cmd=11 transaction; reset clears it.

Decomposition:
- Package spi_pkg holds:
  - cmd encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_BITS=11, RD_BITS=8;
  - FSM state enum {IDLE, SETUP, SHIFT_TX, TURN, SHIFT_RX, HOLD, GAP}.
- One sub-module, spi_sclk_gen: CLK_DIV divider with enable, producing sclk, rise_en and fall_en.

Test Plan:
- Write address: start, cmd=00, payload=0xFD, CLK_DIV=1 -> mosi at rising edges 0,0,0,1,1,1,1,1,1,0,1; ss_n low 13 T; done after 14 T = 28 clk; rd_data stays 0.
- Write data: cmd=01, payload=0xFC -> mosi 0,0,1,1,1,1,1,1,1,0,0. Against the slave+RAM model, RAM[0xFD]=0xFC.
- Read address then read data:
  - cmd=10, payload=0xF9 -> mosi 1,1,0,1,1,1,1,1,0,0,1.
  - Then cmd=11, payload=0xF9 -> mosi 1,1,1,1,1,1,1,1,0,0,1.
  - With the slave returning RAM[0xF9]=0xA5 -> rd_data=0xA5 at done, 24 T after start.
- Busy rules: start during busy (cmd=00, payload=0x12) -> no effect on frame or count. start coincident with done -> accepted the next cycle; exactly one extra frame.
- Reset mid-frame: assert rst at bit 5 of SHIFT_TX -> immediately ss_n=1, sclk=0, mosi=0, busy=0, no done. A new start then produces a full, correct frame.
- CLK_DIV=3: cmd=00, payload=0x5A -> sclk half-period 3 clk; bit order 0,0,0,0,1,0,1,1,0,1,0; done after 84 clk.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller.
// Command codes, frame sizes and FSM states.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 11;
    localparam int RD_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_TX,
        TURN,
        SHIFT_RX,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Requester-side bus of the SPI master controller.
// master: the requester; slave: the controller.
interface spi_master_ctrl_if;

    logic       start;
    logic [1:0] cmd;
    logic [7:0] payload;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;

    modport master (
        output start, cmd, payload,
        input  busy, done, rd_data
    );

    modport slave (
        input  start, cmd, payload,
        output busy, done, rd_data
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: half-period ticks, sclk and edge strobes.
// t_end marks the last clk of each full sclk period.
module spi_sclk_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tog_en,
    output logic sclk,
    output logic rise_en,
    output logic fall_en,
    output logic t_end
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;
    logic         half;
    logic         tick;

    assign tick    = en && (cnt == W'(CLK_DIV - 1));
    assign rise_en = tick && tog_en && !sclk;
    assign fall_en = tick && tog_en && sclk;
    assign t_end   = tick && half;

    // Divider count, half-period phase and the toggling sclk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            half <= 1'b0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            half <= 1'b0;
            sclk <= 1'b0;
        end else begin
            if (tick) begin
                cnt  <= '0;
                half <= ~half;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (!tog_en)
                sclk <= 1'b0;
            else if (tick)
                sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master for the 11-bit command frame.
// Optional 8-bit read-back after a turnaround gap.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV       = 1,
    parameter int RD_TURNAROUND = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_ctrl_if.slave    req,
    output logic                sclk,
    output logic                ss_n,
    output logic                mosi,
    input  logic                miso
);

    localparam logic [3:0] FB = 4'(FRAME_BITS);
    localparam logic [3:0] RB = 4'(RD_BITS);
    localparam logic [3:0] TA = 4'(RD_TURNAROUND);

    state_t      state, state_nx;
    logic [10:0] sr;
    logic [3:0]  bit_cnt;
    logic [7:0]  rd_shift;
    logic [7:0]  rd_q;
    logic        is_rd;
    logic        tog_en;
    logic        rise_en;
    logic        fall_en;
    logic        t_end;
    logic        done_c;

    assign tog_en = (state == SHIFT_TX) || (state == TURN) ||
                    (state == SHIFT_RX);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (state != IDLE),
        .tog_en  (tog_en),
        .sclk    (sclk),
        .rise_en (rise_en),
        .fall_en (fall_en),
        .t_end   (t_end)
    );

    assign req.busy    = (state != IDLE);
    assign req.done    = done_c;
    assign req.rd_data = rd_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state, pin levels and the completion strobe.
    always_comb begin
        state_nx = state;
        done_c   = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req.start)
                    state_nx = SETUP;
            end
            SETUP: begin
                ss_n = 1'b0;
                mosi = sr[10];
                if (t_end)
                    state_nx = SHIFT_TX;
            end
            SHIFT_TX: begin
                ss_n = 1'b0;
                mosi = sr[10];
                if (fall_en && bit_cnt == FB) begin
                    if (!is_rd)
                        state_nx = HOLD;
                    else if (TA == 4'd0)
                        state_nx = SHIFT_RX;
                    else
                        state_nx = TURN;
                end
            end
            TURN: begin
                ss_n = 1'b0;
                if (fall_en && bit_cnt == TA - 4'd1)
                    state_nx = SHIFT_RX;
            end
            SHIFT_RX: begin
                ss_n = 1'b0;
                if (fall_en && bit_cnt == RB)
                    state_nx = HOLD;
            end
            HOLD: begin
                ss_n = 1'b0;
                if (t_end)
                    state_nx = GAP;
            end
            GAP: begin
                if (t_end) begin
                    done_c   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Frame latch and shift, edge counting and read-back capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            bit_cnt  <= '0;
            rd_shift <= '0;
            rd_q     <= '0;
            is_rd    <= 1'b0;
        end else begin
            if (state == IDLE && req.start) begin
                sr    <= {req.cmd[1], req.cmd, req.payload};
                is_rd <= (req.cmd == CMD_RD_DATA);
            end
            if (state != state_nx)
                bit_cnt <= '0;
            else if ((state == SHIFT_TX || state == SHIFT_RX) && rise_en)
                bit_cnt <= bit_cnt + 4'd1;
            else if (state == TURN && fall_en)
                bit_cnt <= bit_cnt + 4'd1;
            if (state == SHIFT_TX && fall_en)
                sr <= {sr[9:0], 1'b0};
            if (state == SHIFT_RX && rise_en)
                rd_shift <= {rd_shift[6:0], miso};
            if (state == SHIFT_RX && fall_en && bit_cnt == RB)
                rd_q <= rd_shift;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised bench for spi_master_ctrl with a behavioural
// SPI slave + RAM and a transaction-level reference model.
module tb_spi_master_ctrl;

    localparam int TA = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] payload = 8'h00;
    logic       sel = 1'b0;
    logic       miso = 1'b0;

    always #5 clk = ~clk;

    spi_master_ctrl_if if1 ();
    spi_master_ctrl_if if3 ();

    assign if1.start   = start && !sel;
    assign if1.cmd     = cmd;
    assign if1.payload = payload;
    assign if3.start   = start && sel;
    assign if3.cmd     = cmd;
    assign if3.payload = payload;

    logic sclk1, ss1, mosi1;
    logic sclk3, ss3, mosi3;

    spi_master_ctrl #(.CLK_DIV(1), .RD_TURNAROUND(TA)) dut1 (
        .clk(clk), .rst(rst), .req(if1),
        .sclk(sclk1), .ss_n(ss1), .mosi(mosi1), .miso(miso)
    );

    spi_master_ctrl #(.CLK_DIV(3), .RD_TURNAROUND(TA)) dut3 (
        .clk(clk), .rst(rst), .req(if3),
        .sclk(sclk3), .ss_n(ss3), .mosi(mosi3), .miso(miso)
    );

    wire       m_sclk = sel ? sclk3 : sclk1;
    wire       m_ss   = sel ? ss3 : ss1;
    wire       m_mosi = sel ? mosi3 : mosi1;
    wire       m_busy = sel ? if3.busy : if1.busy;
    wire       m_done = sel ? if3.done : if1.done;
    wire [7:0] m_rd   = sel ? if3.rd_data : if1.rd_data;

    int n_checks = 0;
    int n_pass = 0;

    // Behavioural slave with RAM.
    logic [7:0]  sram [256];
    logic [7:0]  s_wa = 8'h00, s_ra = 8'h00, s_buf = 8'h00;
    logic [10:0] fr = '0, last_frame = '0;
    int          rcnt = 0, last_rcnt = 0, nframes = 0, sj;
    int          sslow = 0, hicnt = 0;

    always @(negedge m_ss) begin
        rcnt = 0;
        fr = '0;
        miso = 1'b0;
        nframes++;
    end

    always @(posedge m_ss) begin
        last_frame = fr;
        last_rcnt = rcnt;
    end

    always @(posedge m_sclk) begin
        if (m_ss === 1'b0) begin
            if (rcnt < 11) begin
                fr = {fr[9:0], m_mosi};
                if (rcnt == 10) begin
                    case (fr[9:8])
                        2'b00: s_wa = fr[7:0];
                        2'b01: sram[s_wa] = fr[7:0];
                        2'b10: s_ra = fr[7:0];
                        default: s_buf = sram[s_ra];
                    endcase
                end
            end
            rcnt++;
        end
    end

    always @(negedge m_sclk) begin
        if (m_ss === 1'b0) begin
            sj = rcnt - 11 - TA;
            if (sj >= 0 && sj < 8)
                miso = s_buf[7 - sj];
        end
    end

    always @(negedge clk) begin
        if (m_ss === 1'b0) sslow++;
        if (m_sclk === 1'b1) hicnt++;
    end

    // Transaction-level reference model.
    logic [7:0] mram [256];
    logic [7:0] m_wa = 8'h00, m_ra = 8'h00;
    logic [7:0] exp_rd1 = 8'h00, exp_rd3 = 8'h00;
    int         fstart = 0;

    function automatic int exp_lat(int div, logic [1:0] c);
        return 2 * div * ((c == 2'b11) ? (22 + TA) : 14);
    endfunction

    task automatic model_apply(input logic [1:0] c, input logic [7:0] p);
        case (c)
            2'b00: m_wa = p;
            2'b01: mram[m_wa] = p;
            2'b10: m_ra = p;
            default: begin
                if (sel) exp_rd3 = mram[m_ra];
                else     exp_rd1 = mram[m_ra];
            end
        endcase
    endtask

    function automatic logic [7:0] exp_rd();
        return sel ? exp_rd3 : exp_rd1;
    endfunction

    // Launch one transaction; optional stray start at cycle noise_at.
    task automatic drive(input logic [1:0] c, input logic [7:0] p,
                         input int noise_at, output int lat);
        @(negedge clk);
        cmd = c;
        payload = p;
        start = 1'b1;
        sslow = 0;
        hicnt = 0;
        fstart = nframes;
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (m_done === 1'b1) begin
                lat = n;
                break;
            end
            start = (n == noise_at);
            cmd = start ? 2'b00 : 2'($urandom);
            payload = start ? 8'h12 : 8'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            $display("FAIL reset_busy_done: got %b%b want 00", if1.busy, if1.done);
        end else n_pass++;
        n_checks++;
        if ({ss1, sclk1, mosi1} !== 3'b100) begin
            $display("FAIL reset_pins: got %b want 100", {ss1, sclk1, mosi1});
        end else n_pass++;
        n_checks++;
        if (if1.rd_data !== 8'h00 || if3.rd_data !== 8'h00) begin
            $display("FAIL reset_rd_data: got %h/%h want 00", if1.rd_data, if3.rd_data);
        end else n_pass++;
        n_checks++;
        if ({ss3, sclk3, mosi3, if3.busy} !== 4'b1000) begin
            $display("FAIL reset_div3: got %b want 1000", {ss3, sclk3, mosi3, if3.busy});
        end else n_pass++;
        n_checks++;
    endtask

    task automatic test_frames();
        logic [1:0] dc [6];
        logic [7:0] dp [6];
        logic [1:0] c;
        logic [7:0] p;
        int lat;
        dc = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
        dp = '{8'hFD, 8'hFC, 8'hF9, 8'hF9, 8'hFD, 8'h3C};
        for (int i = 0; i < 16; i++) begin
            if (i < 6) begin
                c = dc[i];
                p = dp[i];
            end else begin
                c = 2'($urandom);
                p = 8'($urandom);
            end
            drive(c, p, 0, lat);
            model_apply(c, p);
            n_checks++;
            if (lat !== exp_lat(1, c))
                $display("FAIL frame%0d_latency: got %0d want %0d", i, lat, exp_lat(1, c));
            else n_pass++;
            n_checks++;
            if (last_frame !== {c[1], c, p})
                $display("FAIL frame%0d_mosi: got %h want %h", i, last_frame, {c[1], c, p});
            else n_pass++;
            n_checks++;
            if (last_rcnt !== ((c == 2'b11) ? 19 + TA : 11))
                $display("FAIL frame%0d_edges: got %0d want %0d", i, last_rcnt,
                         (c == 2'b11) ? 19 + TA : 11);
            else n_pass++;
            n_checks++;
            if (sslow !== 2 * ((c == 2'b11) ? 21 + TA : 13))
                $display("FAIL frame%0d_ss_low: got %0d want %0d", i, sslow,
                         2 * ((c == 2'b11) ? 21 + TA : 13));
            else n_pass++;
            n_checks++;
            if (m_rd !== exp_rd() || nframes - fstart !== 1)
                $display("FAIL frame%0d_rd_data: got %h/%0d want %h/1", i, m_rd,
                         nframes - fstart, exp_rd());
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (m_busy !== 1'b0)
                $display("FAIL frame%0d_busy_end: got %b want 0", i, m_busy);
            else n_pass++;
        end
    endtask

    task automatic test_busy_ignore();
        logic [1:0] c;
        logic [7:0] p;
        int lat, nb;
        for (int i = 0; i < 2; i++) begin
            c = (i == 0) ? 2'b01 : 2'b11;
            p = 8'($urandom);
            drive(c, p, (i == 0) ? 7 : 30, lat);
            model_apply(c, p);
            nb = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (m_busy === 1'b1) nb++;
            end
            n_checks++;
            if (lat !== exp_lat(1, c) || last_frame !== {c[1], c, p})
                $display("FAIL busy_ignore%0d_frame: got %0d/%h want %0d/%h", i, lat,
                         last_frame, exp_lat(1, c), {c[1], c, p});
            else n_pass++;
            n_checks++;
            if (nb !== 0 || nframes - fstart !== 1)
                $display("FAIL busy_ignore%0d_extra: got busy=%0d frames=%0d want 0/1", i,
                         nb, nframes - fstart);
            else n_pass++;
            n_checks++;
            if (m_rd !== exp_rd())
                $display("FAIL busy_ignore%0d_rd: got %h want %h", i, m_rd, exp_rd());
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] c2;
        logic [7:0] p2;
        int lat, f0, n2, nb;
        drive(2'b10, 8'hFD, 0, lat);
        model_apply(2'b10, 8'hFD);
        f0 = fstart;
        c2 = 2'b11;
        p2 = 8'($urandom);
        start = 1'b1;
        cmd = c2;
        payload = p2;
        @(posedge clk);
        #1;
        n_checks++;
        if (m_busy !== 1'b0)
            $display("FAIL b2b_done_cycle: got busy=%b want 0", m_busy);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (m_busy !== 1'b1)
            $display("FAIL b2b_accept: got busy=%b want 1", m_busy);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n2 = -1;
        for (int n = 1; n <= 400; n++) begin
            if (m_done === 1'b1) begin
                n2 = n;
                break;
            end
            @(negedge clk);
        end
        model_apply(c2, p2);
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_busy === 1'b1) nb++;
        end
        n_checks++;
        if (n2 !== exp_lat(1, c2) || last_frame !== {c2[1], c2, p2})
            $display("FAIL b2b_second: got %0d/%h want %0d/%h", n2, last_frame,
                     exp_lat(1, c2), {c2[1], c2, p2});
        else n_pass++;
        n_checks++;
        if (nframes - f0 !== 2 || nb !== 0 || m_rd !== exp_rd())
            $display("FAIL b2b_count: got frames=%0d busy=%0d rd=%h want 2/0/%h",
                     nframes - f0, nb, m_rd, exp_rd());
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int ok, nd, lat;
        @(negedge clk);
        cmd = 2'b01;
        payload = 8'h77;
        start = 1'b1;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (rcnt == 5 && m_ss === 1'b0) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (ok !== 1)
            $display("FAIL midframe_reach: got %0d want 1", ok);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ss1, sclk1, mosi1, if1.busy, if1.done} !== 5'b10000)
            $display("FAIL midframe_reset_pins: got %b want 10000",
                     {ss1, sclk1, mosi1, if1.busy, if1.done});
        else n_pass++;
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (if1.done !== 1'b0) nd++;
        end
        rst = 1'b0;
        exp_rd1 = 8'h00;
        exp_rd3 = 8'h00;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if1.done !== 1'b0 || if1.busy !== 1'b0) nd++;
        end
        n_checks++;
        if (nd !== 0 || if1.rd_data !== 8'h00)
            $display("FAIL midframe_no_done: got %0d/%h want 0/00", nd, if1.rd_data);
        else n_pass++;
        drive(2'b11, 8'h00, 0, lat);
        model_apply(2'b11, 8'h00);
        n_checks++;
        if (lat !== exp_lat(1, 2'b11) || last_frame !== 11'h700 || m_rd !== exp_rd())
            $display("FAIL midframe_recover: got %0d/%h/%h want %0d/700/%h", lat,
                     last_frame, m_rd, exp_lat(1, 2'b11), exp_rd());
        else n_pass++;
    endtask

    task automatic test_clkdiv3();
        logic [7:0] p;
        int lat;
        sel = 1'b1;
        drive(2'b00, 8'h5A, 0, lat);
        model_apply(2'b00, 8'h5A);
        n_checks++;
        if (lat !== 84 || last_frame !== 11'h05A)
            $display("FAIL div3_write: got %0d/%h want 84/05a", lat, last_frame);
        else n_pass++;
        n_checks++;
        if (hicnt !== 33 || sslow !== 78)
            $display("FAIL div3_timing: got hi=%0d ss=%0d want 33/78", hicnt, sslow);
        else n_pass++;
        p = 8'($urandom);
        drive(2'b10, p, 0, lat);
        model_apply(2'b10, p);
        drive(2'b11, 8'($urandom), 0, lat);
        model_apply(2'b11, 8'h00);
        n_checks++;
        if (lat !== exp_lat(3, 2'b11) || if3.rd_data !== exp_rd3 || if1.rd_data !== exp_rd1)
            $display("FAIL div3_read: got %0d/%h/%h want %0d/%h/%h", lat, if3.rd_data,
                     if1.rd_data, exp_lat(3, 2'b11), exp_rd3, exp_rd1);
        else n_pass++;
        @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            sram[i] = v;
            mram[i] = v;
        end
        sram[8'hF9] = 8'hA5;
        mram[8'hF9] = 8'hA5;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_frames();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midframe();
        test_clkdiv3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
